// File: rtl/mvm_stream.sv
// rtl/mvm_stream.sv - streamed K x K signed matrix-vector multiplier with P parallel MAC lanes
module mvm_stream #(
   parameter int K    = 4,
   parameter int P    = 2,
   parameter int B    = 8,
   parameter int PIPE = 0,
   localparam int AW  = 2*B + $clog2(K),
   localparam int IW  = $clog2(K)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sel,
   input  logic signed [B-1:0]  in_data,
   input  logic                 start,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [AW-1:0] out_data,
   output logic [IW-1:0]        out_idx,
   output logic                 done
);
   localparam int NS = K / P;
   localparam int LW = (P > 1) ? $clog2(P) : 1;
   localparam int SW = (NS > 1) ? $clog2(NS) : 1;
   localparam int PL = K + 2 + PIPE;
   localparam int CW = $clog2(PL + 1);

   typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;
   state_t state;

   // Row r lives in lane r%P, slot r/P so each lane reads its own row every pass.
   logic signed [B-1:0]  a_mem [P][NS][K];
   logic signed [B-1:0]  x_mem [K];
   logic signed [AW-1:0] y_mem [K];

   logic [IW-1:0] m_col, v_cnt, oc;
   logic [LW-1:0] m_lane;
   logic [SW-1:0] m_slot, q;
   logic [CW-1:0] cyc;
   logic          a_loaded, x_loaded;
   logic          load_fire, pass_end;
   logic [IW-1:0] rd_col;

   logic signed [B-1:0]   a_op [P];
   logic signed [B-1:0]   x_op;
   logic signed [2*B-1:0] prod [P];
   logic signed [2*B-1:0] prod_f [P];
   logic signed [AW-1:0]  acc [P];
   logic signed [AW-1:0]  acc_nxt [P];
   logic                  v1, v2, vf;

   assign load_fire = in_valid && in_ready;
   assign pass_end  = (state == COMPUTE) && (cyc == CW'(PL - 1));
   assign rd_col    = cyc[IW-1:0];

   always_ff @(posedge clk) begin
      if (!reset && load_fire) begin
         if (in_sel)
            x_mem[v_cnt] <= in_data;
         else
            a_mem[m_lane][m_slot][m_col] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         m_col     <= '0;
         m_lane    <= '0;
         m_slot    <= '0;
         v_cnt     <= '0;
         a_loaded  <= 1'b0;
         x_loaded  <= 1'b0;
         q         <= '0;
         cyc       <= '0;
         oc        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load_fire) begin
                  if (in_sel) begin
                     if (v_cnt == IW'(K - 1)) begin
                        v_cnt    <= '0;
                        x_loaded <= 1'b1;
                     end else begin
                        v_cnt <= v_cnt + 1'b1;
                     end
                  end else if (m_col == IW'(K - 1)) begin
                     m_col <= '0;
                     if (m_lane == LW'(P - 1)) begin
                        m_lane <= '0;
                        if (m_slot == SW'(NS - 1)) begin
                           m_slot   <= '0;
                           a_loaded <= 1'b1;
                        end else begin
                           m_slot <= m_slot + 1'b1;
                        end
                     end else begin
                        m_lane <= m_lane + 1'b1;
                     end
                  end else begin
                     m_col <= m_col + 1'b1;
                  end
               end else if (start && a_loaded && x_loaded) begin
                  state    <= COMPUTE;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  q        <= '0;
                  cyc      <= '0;
               end
            end
            COMPUTE: begin
               if (pass_end) begin
                  cyc <= '0;
                  if (q == SW'(NS - 1)) begin
                     state <= OUTPUT;
                     oc    <= '0;
                  end else begin
                     q <= q + 1'b1;
                  end
               end else begin
                  cyc <= cyc + 1'b1;
               end
            end
            OUTPUT: begin
               // out_valid is low only on the first OUTPUT cycle, when y[0] is presented.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  out_data  <= y_mem[oc];
                  out_idx   <= oc;
               end else if (out_ready) begin
                  if (oc == IW'(K - 1)) begin
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                     x_loaded  <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     oc       <= oc + 1'b1;
                     out_data <= y_mem[oc + 1'b1];
                     out_idx  <= oc + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operand read -> product -> (optional product register) -> accumulate.
   always_ff @(posedge clk) begin
      if (reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= (state == COMPUTE) && (cyc < CW'(K));
         v2 <= v1;
      end
      x_op <= x_mem[rd_col];
      for (int l = 0; l < P; l++) begin
         a_op[l] <= a_mem[l][q][rd_col];
         prod[l] <= (2*B)'(a_op[l]) * (2*B)'(x_op);
      end
   end

   generate
      if (PIPE != 0) begin : g_pipe
         logic signed [2*B-1:0] prod_r [P];
         logic                  v3;
         always_ff @(posedge clk) begin
            if (reset)
               v3 <= 1'b0;
            else
               v3 <= v2;
            prod_r <= prod;
         end
         assign vf     = v3;
         assign prod_f = prod_r;
      end else begin : g_nopipe
         assign vf     = v2;
         assign prod_f = prod;
      end
   endgenerate

   always_comb begin
      for (int l = 0; l < P; l++) begin
         acc_nxt[l] = acc[l];
         if (vf)
            acc_nxt[l] = acc[l] + AW'(prod_f[l]);
      end
   end

   // The final product lands in the last pass cycle, so results are taken from acc_nxt.
   always_ff @(posedge clk) begin
      for (int l = 0; l < P; l++) begin
         if (reset || pass_end)
            acc[l] <= '0;
         else
            acc[l] <= acc_nxt[l];
         if (!reset && pass_end)
            y_mem[IW'(int'(q) * P + l)] <= acc_nxt[l];
      end
   end

endmodule

// File: tb/tb_mvm_stream.sv
// tb/tb_mvm_stream.sv - directed self-checking bench for mvm_stream (PIPE=0 and PIPE=1 instances)
module tb_mvm_stream;
   localparam int AW = 18;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic in_sel = 1'b0;
   logic start = 1'b0;
   logic out_ready = 1'b1;
   logic signed [7:0] in_data = '0;
   logic sel = 1'b0;

   logic in_ready0, in_ready1, busy0, busy1, ov0, ov1, done0, done1;
   logic signed [AW-1:0] od0, od1;
   logic [1:0] oi0, oi1;

   logic ov, dn, by;
   logic signed [AW-1:0] od;
   logic [1:0] oi;
   assign ov = sel ? ov1 : ov0;
   assign dn = sel ? done1 : done0;
   assign by = sel ? busy1 : busy0;
   assign od = sel ? od1 : od0;
   assign oi = sel ? oi1 : oi0;

   int n_cmp = 0;
   int n_bad = 0;

   mvm_stream #(.K(4), .P(2), .B(8), .PIPE(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .in_sel(in_sel), .in_data(in_data), .start(start), .busy(busy0),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_idx(oi0), .done(done0));

   mvm_stream #(.K(4), .P(2), .B(8), .PIPE(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .in_sel(in_sel), .in_data(in_data), .start(start), .busy(busy1),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_idx(oi1), .done(done1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic load_one(input bit s, input int v);
      in_valid = 1'b1;
      in_sel   = s;
      in_data  = 8'(v);
      step;
      in_valid = 1'b0;
   endtask

   task automatic load_mat(input int m[16]);
      for (int i = 0; i < 16; i++) load_one(1'b0, m[i]);
   endtask

   task automatic load_vec(input int v[4]);
      for (int i = 0; i < 4; i++) load_one(1'b1, v[i]);
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      while ((busy0 || busy1) && n < 200) begin
         step;
         n++;
      end
      check("wait_idle", longint'(busy0 | busy1), 0);
   endtask

   task automatic run(input string tag, input int exp[4], input bit bp, input int lat);
      int n, cnt, k;
      out_ready = 1'b1;
      start = 1'b1;
      step;
      start = 1'b0;
      check({tag, "_busy"}, by, 1);
      n = 0;
      while (!ov && n < 60) begin
         step;
         n++;
      end
      check({tag, "_lat"}, n, lat);
      cnt = 0;
      k = 0;
      while (cnt < 4 && k < 100) begin
         out_ready = bp ? (k % 3 == 0) : 1'b1;
         if (ov) begin
            check($sformatf("%s_idx%0d", tag, cnt), oi, cnt);
            check($sformatf("%s_y%0d", tag, cnt), od, exp[cnt]);
            if (out_ready) cnt++;
         end
         step;
         k++;
      end
      check({tag, "_cnt"}, cnt, 4);
      check({tag, "_done"}, dn, 1);
      check({tag, "_ovlow"}, ov, 0);
      out_ready = 1'b1;
      step;
      check({tag, "_done1"}, dn, 0);
      check({tag, "_idle"}, by, 0);
      wait_idle;
   endtask

   initial begin
      int ident[16];
      int mb[16];
      int mneg[16];
      int v[4];
      int e[4];
      int seen;

      ident = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
      mb    = '{1,2,3,4, -1,0,1,0, 127,-128,0,0, 0,0,0,-2};
      for (int i = 0; i < 16; i++) mneg[i] = -128;

      reset = 1'b1;
      step;
      step;
      check("rst_in_ready", in_ready0, 1);
      check("rst_busy", busy0, 0);
      check("rst_out_valid", ov0, 0);
      check("rst_done", done0, 0);
      check("rst_out_data", od0, 0);
      check("rst_out_idx", oi0, 0);
      reset = 1'b0;
      step;
      check("post_rst_ready", in_ready0, 1);

      start = 1'b1;
      step;
      start = 1'b0;
      check("empty_start_ignored", busy0, 0);

      load_mat(ident);
      v = '{1,2,3,4};
      load_vec(v);
      e = '{1,2,3,4};
      run("ident", e, 1'b0, 13);

      start = 1'b1;
      step;
      start = 1'b0;
      check("reuse_early_start", busy0, 0);
      step;
      check("reuse_early_start2", busy0, 0);
      v = '{2,0,0,-1};
      load_vec(v);
      e = '{2,0,0,-1};
      run("reuse", e, 1'b0, 13);

      load_mat(mb);
      v = '{1,2,3,4};
      load_vec(v);
      in_valid = 1'b1;
      in_sel   = 1'b1;
      in_data  = 8'sd5;
      start    = 1'b1;
      step;
      in_valid = 1'b0;
      start    = 1'b0;
      check("combo_start_ignored", busy0, 0);
      check("combo_in_ready", in_ready0, 1);
      load_one(1'b1, 6);
      load_one(1'b1, 7);
      load_one(1'b1, 8);
      e = '{70, 2, -133, -16};
      run("bp", e, 1'b1, 13);

      load_mat(mneg);
      v = '{-128,-128,-128,-128};
      load_vec(v);
      e = '{65536, 65536, 65536, 65536};
      run("neg", e, 1'b0, 13);

      v = '{1,2,3,4};
      load_vec(v);
      start = 1'b1;
      step;
      start = 1'b0;
      step;
      step;
      reset = 1'b1;
      step;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (ov0 || done0 || ov1 || done1) seen = 1;
         step;
      end
      check("abort_quiet", seen, 0);
      check("abort_in_ready", in_ready0, 1);
      check("abort_busy", busy0, 0);
      start = 1'b1;
      step;
      start = 1'b0;
      check("abort_start_ignored", busy0, 0);

      sel = 1'b1;
      load_mat(ident);
      v = '{1,2,3,4};
      load_vec(v);
      e = '{1,2,3,4};
      run("pipe", e, 1'b0, 15);
      sel = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mvm_stream.md
MVM_STREAM -- requirements
Module: mvm_stream

Interface
REQ-001 Parameter K, default 4: matrix dimension (K x K matrix, K-element vector); K >= 2.
REQ-002 Parameter P, default 2: parallel MAC lanes; P divides K; P >= 1.
REQ-003 Parameter B, default 8: signed input element width.
REQ-004 Parameter PIPE, default 0: 1 adds one register stage after the multiplier.
REQ-005 Derived width AW = 2*B + clog2(K): signed accumulator/result width.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 in_valid  input  1  load element present.
REQ-009 in_ready  output  1  block accepts load element.
REQ-010 in_sel  input  1  0 = matrix element (row-major), 1 = vector element.
REQ-011 in_data  input  B  signed load element.
REQ-012 start  input  1  single-cycle compute request.
REQ-013 busy  output  1  high from accepted start until the last result handshake.
REQ-014 out_valid  output  1  result present.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 out_data  output  AW  signed result y[out_idx].
REQ-017 out_idx  output  clog2(K)  row index of out_data.
REQ-018 done  output  1  one-cycle pulse after the final result handshake.

Function
REQ-019 FSM states: IDLE, COMPUTE, OUTPUT; load handshakes occur only in IDLE.
REQ-020 in_ready = 1 only in IDLE; a load transfers when in_valid && in_ready.
REQ-021 Matrix load: element n (counter 0..K*K-1) goes to row n/K, column n%K; row r is stored in lane r%P, slot r/P; the counter wraps to 0 after K*K-1 and a_loaded is set at the wrap.
REQ-022 Vector load: element n (counter 0..K-1) goes to x[n]; the counter wraps after K-1 and x_loaded is set at the wrap.
REQ-023 A further load after a wrap overwrites from address 0; the loaded flag stays set.
REQ-024 start is accepted only in IDLE with a_loaded && x_loaded && !(in_valid && in_ready); otherwise it is ignored with no state change.
REQ-025 A load handshake and start in the same cycle: the load wins and start is ignored.
REQ-026 COMPUTE runs K/P passes; pass q has lane l compute y[q*P+l] = sum over j of A[q*P+l][j]*x[j], issuing j = 0..K-1 on consecutive cycles.
REQ-027 The accumulator is cleared at the start of each pass; each pass takes exactly K+2+PIPE cycles (read, multiply, accumulate drain); passes run back-to-back.
REQ-028 Arithmetic is full-precision signed: B x B gives a 2B-bit product, summed into AW bits; overflow is impossible by construction.
REQ-029 At the end of each pass, all P lane results are written to result buffer Y[K] at index q*P+l.
REQ-030 After the last pass: enter OUTPUT; out_valid asserts the next cycle with out_idx = 0.
REQ-031 OUTPUT streams Y[0..K-1] in order, advancing on out_valid && out_ready.
REQ-032 With out_ready low, out_data and out_idx are held stable and out_valid stays high.
REQ-033 After the handshake of index K-1: out_valid = 0, done = 1 for one cycle, return to IDLE.
REQ-034 On return to IDLE, x_loaded is cleared and a_loaded is retained, so the matrix is reused across vectors.
REQ-035 The matrix may be reloaded in IDLE at any time; a partial reload leaves a_loaded set and mixes old and new rows.

Reset
REQ-036 reset, synchronous and checked first every cycle, forces: state IDLE; in_ready 1 on the following cycle; busy, out_valid, done 0; out_data, out_idx 0.
REQ-037 reset clears both load counters and both loaded flags, discards any in-flight compute or output, and leaves memory contents undefined.
REQ-038 reset asserted during COMPUTE or OUTPUT aborts immediately; no done pulse follows.

Verification
REQ-039 K=4, P=2, B=8, PIPE=0: load identity A, x=[1,2,3,4], start, out_ready=1 -> out_data 1,2,3,4 at out_idx 0..3; done once; first out_valid exactly 2*(4+2)+1 cycles after start.
REQ-040 All A = -128, all x = -128, K=4 -> every result = 65536 (AW=18); no sign error.
REQ-041 Reuse: after REQ-039, load only x=[2,0,0,-1], start -> results 2,0,0,-1; start issued before the vector load is ignored (busy stays 0).
REQ-042 Backpressure: out_ready toggles 1,0,0,1,... -> each result is held stable while stalled; order and values are unchanged; done follows the 4th handshake.
REQ-043 Reset asserted on cycle 3 of COMPUTE -> out_valid never asserts, no done, in_ready=1 after reset; a following start without reload is ignored.
REQ-044 Same cycle load and start in IDLE -> load accepted, start ignored; PIPE=1 run of REQ-039 -> identical values, first out_valid one cycle per pass later.
